register_file_mp: RTL

//  Parametrised multi-port CPU register file: 2 combinational read ports, 2 write ports.

---
 rtl/register_file_mp.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file: two combinational read ports, two write ports (B wins),
// optional hardwired zero register, write-to-read bypass, background clear and debug read.
module register_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr_1,
    input  logic [ADDR_WIDTH-1:0] rd_addr_2,
    output logic [DATA_WIDTH-1:0] rd_data_1,
    output logic [DATA_WIDTH-1:0] rd_data_2,
    input  logic                  wr_en_a,
    input  logic [ADDR_WIDTH-1:0] wr_addr_a,
    input  logic [DATA_WIDTH-1:0] wr_data_a,
    input  logic                  wr_en_b,
    input  logic [ADDR_WIDTH-1:0] wr_addr_b,
    input  logic [DATA_WIDTH-1:0] wr_data_b,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_valid,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 32'd1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(32'd1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  dbg_valid_q, dbg_valid_d;
    logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
    logic                  we_a_s, we_b_s;

    function automatic logic is_zero_addr(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG != 32'd0) && (addr == {ADDR_WIDTH{1'b0}});
    endfunction

    // Bypass picks the in-flight write (B over A); the zero register overrides everything.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  we_a,
        input logic [ADDR_WIDTH-1:0] addr_a,
        input logic [DATA_WIDTH-1:0] data_a,
        input logic                  we_b,
        input logic [ADDR_WIDTH-1:0] addr_b,
        input logic [DATA_WIDTH-1:0] data_b
    );
        logic [DATA_WIDTH-1:0] val;
        if (is_zero_addr(addr)) begin
            val = {DATA_WIDTH{1'b0}};
        end else if ((BYPASS != 32'd0) && we_b && (addr_b == addr)) begin
            val = data_b;
        end else if ((BYPASS != 32'd0) && we_a && (addr_a == addr)) begin
            val = data_a;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    assign busy      = (state_q == ST_CLEAR);
    assign dbg_valid = dbg_valid_q;
    assign dbg_data  = dbg_data_q;

    // Effective write enables: dropped while clearing or when aimed at the zero register.
    always_comb begin
        we_a_s = wr_en_a && (state_q == ST_IDLE) && !is_zero_addr(wr_addr_a);
        we_b_s = wr_en_b && (state_q == ST_IDLE) && !is_zero_addr(wr_addr_b);
    end

    // Combinational read ports.
    always_comb begin
        rd_data_1 = read_port(rd_addr_1, mem_q[rd_addr_1], we_a_s, wr_addr_a, wr_data_a,
                              we_b_s, wr_addr_b, wr_data_b);
        rd_data_2 = read_port(rd_addr_2, mem_q[rd_addr_2], we_a_s, wr_addr_a, wr_data_a,
                              we_b_s, wr_addr_b, wr_data_b);
    end

    // Array next state: port writes in IDLE (B applied last so it wins), one entry zeroed per cycle in CLEAR.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (state_q == ST_CLEAR) begin
            mem_d[cnt_q] = {DATA_WIDTH{1'b0}};
        end else begin
            if (we_a_s) begin
                mem_d[wr_addr_a] = wr_data_a;
            end else begin
                mem_d[wr_addr_a] = mem_d[wr_addr_a];
            end
            if (we_b_s) begin
                mem_d[wr_addr_b] = wr_data_b;
            end else begin
                mem_d[wr_addr_b] = mem_d[wr_addr_b];
            end
        end
    end

    // Clear sequencer next state; the counter wraps to zero on the final step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {ADDR_WIDTH{1'b0}};
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Debug port samples the array before this edge's writes land.
    always_comb begin
        dbg_valid_d = dbg_req;
        if (dbg_req) begin
            dbg_data_d = is_zero_addr(dbg_addr) ? {DATA_WIDTH{1'b0}} : mem_q[dbg_addr];
        end else begin
            dbg_data_d = dbg_data_q;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            state_q     <= ST_IDLE;
            cnt_q       <= {ADDR_WIDTH{1'b0}};
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_data_q  <= dbg_data_d;
        end
    end

endmodule
